// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register bank: FSM states, frame sizing and
// the encoding of the R/W bit at the head of every frame.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    COMMIT
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frameWidth(input int addrW, input int dataW);
    return 1 + addrW + dataW;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing one asynchronous bit into the clk domain;
// both stages clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank written over a mode-0 SPI slave that is oversampled by clk.
// Define SPI_READBACK_EN to return the addressed register on sdo during read frames.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       sdi,
  input  logic                       cs_n,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frameWidth(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam int AW1     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME_W + 1);
  localparam logic [ADDR_W:0]  REG_LIMIT = AW1'(NUM_REGS);

  logic                       sclkSync, sdiSync, csnSync;
  logic                       sclkPrev_q, sclkRise;
  logic                       armed_q;
  state_e                     state_q, state_d;
  logic [FRAME_W-1:0]         shift_q, shift_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]          wrAddr_q, wrAddr_d;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       frameRw, addrOk, validWrite, badFrame;
  logic [ADDR_W-1:0]          frameAddr;
  logic [DATA_W-1:0]          frameData;

  sync2 u_syncSclk (.clk(clk), .rst(rst), .d_i(sclk), .q_o(sclkSync));
  sync2 u_syncSdi  (.clk(clk), .rst(rst), .d_i(sdi),  .q_o(sdiSync));
  sync2 u_syncCsn  (.clk(clk), .rst(rst), .d_i(cs_n), .q_o(csnSync));

  assign sclkRise   = sclkSync & ~sclkPrev_q;
  assign frameRw    = shift_q[FRAME_W-1];
  assign frameAddr  = shift_q[FRAME_W-2 -: ADDR_W];
  assign frameData  = shift_q[DATA_W-1:0];
  assign addrOk     = {1'b0, frameAddr} < REG_LIMIT;
  assign validWrite = (cnt_q == CNT_FULL) && (frameRw == RW_WRITE) && addrOk;
  assign badFrame   = (cnt_q != CNT_FULL) || ((frameRw == RW_WRITE) && !addrOk);

  // armed_q blocks a frame that was already in flight when reset released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      wrAddr_q   <= '0;
      sclkPrev_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      wrAddr_q   <= wrAddr_d;
      sclkPrev_q <= sclkSync;
      armed_q    <= armed_q | csnSync;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    wrAddr_d = wrAddr_q;
    case (state_q)
      IDLE: begin
        if (armed_q && !csnSync) begin
          state_d = SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (csnSync) begin
          state_d = CHECK;
        end else if (sclkRise) begin
          shift_d = {shift_q[FRAME_W-2:0], sdiSync};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (validWrite) begin
          state_d  = COMMIT;
          wrAddr_d = frameAddr;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '0;
    end else if (state_q == COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrAddr_q == ADDR_W'(i)) regs_q[i*DATA_W +: DATA_W] <= frameData;
      end
    end
  end

  assign regs_out  = regs_q;
  assign wr_strobe = (state_q == COMMIT);
  assign wr_addr   = wrAddr_q;
  assign frame_err = (state_q == CHECK) && badFrame;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR_DONE  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA_SHIFT = CNT_W'(ADDR_W + 2);

  logic              sclkFall;
  logic [DATA_W-1:0] sdoShift_q, sdoShift_d, rdData;

  assign sclkFall = ~sclkSync & sclkPrev_q;

  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (shift_d[ADDR_W-1:0] == ADDR_W'(i)) rdData = regs_q[i*DATA_W +: DATA_W];
    end
  end

  // The falling edge right after the load is skipped so the MSB is still on sdo
  // when the master samples the first data-phase rising edge.
  always_comb begin
    sdoShift_d = sdoShift_q;
    if (state_q != SHIFT) begin
      sdoShift_d = '0;
    end else if (!csnSync && sclkRise && cnt_q == CNT_ADDR_DONE && shift_d[ADDR_W] == RW_READ) begin
      sdoShift_d = rdData;
    end else if (!csnSync && sclkFall && cnt_q >= CNT_DATA_SHIFT) begin
      sdoShift_d = sdoShift_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sdoShift_q <= '0;
    else     sdoShift_q <= sdoShift_d;
  end

  assign sdo = (state_q == SHIFT) ? sdoShift_q[DATA_W-1] : 1'b0;
`else
  assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a table of SPI frames with hand-computed
// register/strobe/error expectations, plus reset and mid-frame reset sequences.
module tb_spi_reg_bank;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;
  localparam int NVEC     = 13;

`ifdef SPI_READBACK_EN
  localparam logic [15:0] READ_SDO = 16'h003C;
`else
  localparam logic [15:0] READ_SDO = 16'h0000;
`endif

  logic                       clk = 1'b0;
  logic                       rst, sclk, sdi, cs_n;
  logic                       sdo, wr_strobe, frame_err;
  logic [NUM_REGS*DATA_W-1:0] regs_out;
  logic [ADDR_W-1:0]          wr_addr;

  spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .sdi(sdi), .cs_n(cs_n), .sdo(sdo),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] frame;
    int          len;
    logic [39:0] expRegs;
    int          expStrobes;
    int          expErrs;
    logic [6:0]  expAddr;
    int          expLatency;
    logic [15:0] expSdo;
  } vec_t;

  vec_t        vecs[NVEC];
  int          testsRun = 0;
  int          testsFailed = 0;
  int          strobeCnt = 0;
  int          errCnt = 0;
  logic [6:0]  lastAddr = '0;

  // Pulse counters sampled mid-cycle; a multi-cycle pulse counts more than once.
  always @(negedge clk) begin
    if (wr_strobe) begin
      strobeCnt = strobeCnt + 1;
      lastAddr  = wr_addr;
    end
    if (frame_err) errCnt = errCnt + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Shifts len bits MSB first at sclk = clk/10, capturing sdo before each rising edge.
  task automatic shiftBits(input logic [31:0] frame, input int len, output logic [31:0] cap);
    cap = '0;
    for (int b = len - 1; b >= 0; b--) begin
      sdi = frame[b];
      #50;
      cap  = {cap[30:0], sdo};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
    #60;
    sdi = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] frame, input int len,
                               output logic [31:0] cap, output int latency);
    latency = -1;
    @(posedge clk);
    #1 cs_n = 1'b0;
    #60;
    shiftBits(frame, len, cap);
    @(posedge clk);
    #1 cs_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (latency < 0 && wr_strobe) latency = c;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] cap;
    int          lat;
    int          s0, e0;

    vecs[0]  = '{32'h80A5,  16, 40'h00_00_00_00_A5, 1, 0, 7'd0, 4,  16'h0};
    vecs[1]  = '{32'h8433,  16, 40'h33_00_00_00_A5, 1, 0, 7'd4, 4,  16'h0};
    vecs[2]  = '{32'h8455,  16, 40'h55_00_00_00_A5, 1, 0, 7'd4, 4,  16'h0};
    vecs[3]  = '{32'h8712,  16, 40'h55_00_00_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[4]  = '{32'h4052,  15, 40'h55_00_00_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[5]  = '{32'h18155, 17, 40'h55_00_00_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[6]  = '{32'hF8133, 20, 40'h55_00_00_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[7]  = '{32'h823C,  16, 40'h55_00_3C_00_A5, 1, 0, 7'd2, 4,  16'h0};
    vecs[8]  = '{32'h0200,  16, 40'h55_00_3C_00_A5, 0, 0, 7'd0, -1, READ_SDO};
    vecs[9]  = '{32'h3F80,  15, 40'h55_00_3C_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[10] = '{32'h8501,  16, 40'h55_00_3C_00_A5, 0, 1, 7'd0, -1, 16'h0};
    vecs[11] = '{32'h83C3,  16, 40'h55_C3_3C_00_A5, 1, 0, 7'd3, 4,  16'h0};
    vecs[12] = '{32'h80FF,  16, 40'h55_C3_3C_00_FF, 1, 0, 7'd0, 4,  16'h0};

    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    sdi  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetRegs", 64'(regs_out), 64'h0);
    checkOutput("resetStrobe", 64'(wr_strobe), 64'h0);
    checkOutput("resetErr", 64'(frame_err), 64'h0);
    checkOutput("resetAddr", 64'(wr_addr), 64'h0);
    checkOutput("resetSdo", 64'(sdo), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int v = 0; v < NVEC; v++) begin
      s0 = strobeCnt;
      e0 = errCnt;
      applyStimulus(vecs[v].frame, vecs[v].len, cap, lat);
      checkOutput($sformatf("v%0d regs", v), 64'(regs_out), 64'(vecs[v].expRegs));
      checkOutput($sformatf("v%0d strobes", v), 64'(strobeCnt - s0), 64'(vecs[v].expStrobes));
      checkOutput($sformatf("v%0d errs", v), 64'(errCnt - e0), 64'(vecs[v].expErrs));
      checkOutput($sformatf("v%0d latency", v), 64'(lat), 64'(vecs[v].expLatency));
      checkOutput($sformatf("v%0d sdo", v), 64'(cap[15:0]), 64'(vecs[v].expSdo));
      if (vecs[v].expStrobes > 0)
        checkOutput($sformatf("v%0d wrAddr", v), 64'(lastAddr), 64'(vecs[v].expAddr));
    end

    // Reset lands after 9 bits of 16'h8199; the tail of that frame must be ignored.
    s0 = strobeCnt;
    e0 = errCnt;
    @(posedge clk);
    #1 cs_n = 1'b0;
    #60;
    shiftBits(32'h103, 9, cap);
    rst = 1'b1;
    #30;
    checkOutput("midRstRegs", 64'(regs_out), 64'h0);
    checkOutput("midRstAddr", 64'(wr_addr), 64'h0);
    #30 rst = 1'b0;
    #30;
    shiftBits(32'h19, 7, cap);
    @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("midRstStrobes", 64'(strobeCnt - s0), 64'h0);
    checkOutput("midRstErrs", 64'(errCnt - e0), 64'h0);
    checkOutput("midRstRegsHeld", 64'(regs_out), 64'h0);

    applyStimulus(32'h8177, 16, cap, lat);
    checkOutput("postRstRegs", 64'(regs_out), 64'h00_00_00_77_00);
    checkOutput("postRstStrobes", 64'(strobeCnt - s0), 64'h1);
    checkOutput("postRstErrs", 64'(errCnt - e0), 64'h0);
    checkOutput("postRstAddr", 64'(lastAddr), 64'h1);
    checkOutput("postRstLatency", 64'(lat), 64'h4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
